// File: rtl/toaster_pkg.sv
// Shared types and default cycle constants for the toaster sequencer.
package toaster_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WARMUP    = 2'b01,
    TOAST     = 2'b10,
    COOL_DOWN = 2'b11
  } state_t;

  typedef logic [1:0] level_t;

  localparam int DEF_CNT_W          = 16;
  localparam int DEF_WARMUP_CYC     = 8;
  localparam int DEF_TOAST_BASE_CYC = 16;
  localparam int DEF_TOAST_STEP_CYC = 8;
  localparam int DEF_COOL_CYC       = 12;

endpackage

// File: rtl/toaster_timer.sv
// Loadable down-counter; holds at zero and flags it so phases end on the cycle the count reaches 0.
module toaster_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/toaster_seq.sv
// Toaster heating-cycle sequencer: IDLE -> WARMUP -> TOAST -> COOL_DOWN -> IDLE.
// Define TOASTER_SEQ_OVERTEMP_EN to enable the sticky overtemperature abort/lockout.
module toaster_seq
  import toaster_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int WARMUP_CYC     = DEF_WARMUP_CYC,
  parameter int TOAST_BASE_CYC = DEF_TOAST_BASE_CYC,
  parameter int TOAST_STEP_CYC = DEF_TOAST_STEP_CYC,
  parameter int COOL_CYC       = DEF_COOL_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [1:0] level_i,
  input  logic       cancel_i,
  input  logic       overtemp_i,
  output logic       heater_o,
  output logic       busy_o,
  output logic [1:0] state_o,
  output logic       done_o,
  output logic       fault_o
);

  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_CYC - 1);

  state_t           state_q, state_d;
  level_t           level_q, level_d;
  logic             heater_q, heater_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val, toast_load;
  logic             abort, start_ok;

`ifdef TOASTER_SEQ_OVERTEMP_EN
  assign abort    = cancel_i | overtemp_i;
  assign start_ok = start_i & ~fault_q;
`else
  logic unused_overtemp;
  assign unused_overtemp = overtemp_i;
  assign abort           = cancel_i;
  assign start_ok        = start_i;
`endif

  assign toast_load = CNT_W'(TOAST_BASE_CYC) + CNT_W'(level_q) * CNT_W'(TOAST_STEP_CYC)
                    - CNT_W'(1);

  toaster_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      level_q  <= '0;
      heater_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      heater_q <= heater_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: if (start_ok) begin
        state_d  = WARMUP;
        level_d  = level_i;
        tmr_load = 1'b1;
        tmr_val  = WARM_LOAD;
      end
      WARMUP: if (abort) begin
        state_d  = COOL_DOWN;
        tmr_load = 1'b1;
        tmr_val  = COOL_LOAD;
      end else if (tmr_zero) begin
        state_d  = TOAST;
        tmr_load = 1'b1;
        tmr_val  = toast_load;
      end
      TOAST: if (abort || tmr_zero) begin
        state_d  = COOL_DOWN;
        tmr_load = 1'b1;
        tmr_val  = COOL_LOAD;
      end
      COOL_DOWN: if (tmr_zero) state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    heater_d = (state_d == WARMUP) || (state_d == TOAST);
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == COOL_DOWN) && tmr_zero;
`ifdef TOASTER_SEQ_OVERTEMP_EN
    fault_d  = fault_q | (overtemp_i && ((state_q == WARMUP) || (state_q == TOAST)));
`else
    fault_d  = 1'b0;
`endif
  end

  assign state_o  = state_q;
  assign heater_o = heater_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign fault_o  = fault_q;

endmodule

// File: tb/tb_toaster_seq.sv
// Directed bench for toaster_seq: table of full-cycle scenarios plus hand-written corner sequences.
module tb_toaster_seq;
  import toaster_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start_i, cancel_i, overtemp_i;
  logic [1:0] level_i;
  logic       heater_o, busy_o, done_o, fault_o;
  logic [1:0] state_o;

  int total = 0;
  int bad   = 0;

  toaster_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .level_i    (level_i),
    .cancel_i   (cancel_i),
    .overtemp_i (overtemp_i),
    .heater_o   (heater_o),
    .busy_o     (busy_o),
    .state_o    (state_o),
    .done_o     (done_o),
    .fault_o    (fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    int canc_from;
    int canc_to;
    int start_to;
    int exp_toast;
    int exp_cool;
    int exp_done;
    int exp_heat;
  } case_t;

  case_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Cycle 0 presents start; cycle numbers below count from there.
  task automatic run_case(input case_t c, input int idx);
    int     t_toast, t_cool, t_done, heat, errs;
    state_t s;
    t_toast = -1; t_cool = -1; t_done = -1; heat = 0; errs = 0;
    start_i  = 1'b1;
    level_i  = c.lvl[1:0];
    cancel_i = 1'b0;
    tick();
    for (int cyc = 1; cyc < 200 && t_done < 0; cyc++) begin
      s = state_t'(state_o);
      if (s == TOAST && t_toast < 0) t_toast = cyc;
      if (s == COOL_DOWN && t_cool < 0) t_cool = cyc;
      if (heater_o) heat++;
      if (done_o) t_done = cyc;
      if (busy_o !== (s != IDLE)) errs++;
      if (heater_o !== (s == WARMUP || s == TOAST)) errs++;
      if (done_o && s != IDLE) errs++;
      start_i  = (cyc <= c.start_to);
      cancel_i = (cyc >= c.canc_from && cyc <= c.canc_to);
      level_i  = ~c.lvl[1:0];
      if (t_done < 0) tick();
    end
    start_i  = 1'b0;
    cancel_i = 1'b0;
    check($sformatf("case%0d toast_start", idx), t_toast, c.exp_toast);
    check($sformatf("case%0d cool_start", idx), t_cool, c.exp_cool);
    check($sformatf("case%0d done_cycle", idx), t_done, c.exp_done);
    check($sformatf("case%0d heater_cycles", idx), heat, c.exp_heat);
    check($sformatf("case%0d output_consistency", idx), errs, 0);
    tick();
    check($sformatf("case%0d done_one_cycle", idx), int'(done_o), 0);
    check($sformatf("case%0d idle_after", idx), int'(state_o), int'(IDLE));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done_o && n < 200) begin
      tick();
      n++;
    end
    if (!done_o) check(name, 0, 1);
  endtask

  initial begin
    int errs;

    //        lvl  c_from c_to start_to toast cool done heat
    tbl[0] = '{2, -1, -1,  0,  9, 41, 53, 40};
    tbl[1] = '{0, -1, -1,  0,  9, 25, 37, 24};
    tbl[2] = '{3, -1, -1,  0,  9, 49, 61, 48};
    tbl[3] = '{1, -1, -1, 40,  9, 33, 45, 32};
    tbl[4] = '{2, 20, 20,  0,  9, 21, 33, 20};
    tbl[5] = '{2,  8,  8,  0, -1,  9, 21,  8};
    tbl[6] = '{0, 28, 35,  0,  9, 25, 37, 24};
    tbl[7] = '{2,  3, 14,  0, -1,  4, 16,  3};

    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; overtemp_i = 1'b0; level_i = 2'd0;
    tick();
    tick();
    check("reset state", int'(state_o), int'(IDLE));
    check("reset heater", int'(heater_o), 0);
    check("reset busy", int'(busy_o), 0);
    check("reset done", int'(done_o), 0);
    check("reset fault", int'(fault_o), 0);
    rst = 1'b0;

    // Cancel alone in IDLE does nothing.
    cancel_i = 1'b1;
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (state_o !== 2'b00 || busy_o !== 1'b0 || done_o !== 1'b0) errs++;
    end
    cancel_i = 1'b0;
    check("cancel_in_idle", errs, 0);

    for (int i = 0; i < 8; i++) run_case(tbl[i], i);

    // Start and cancel together in IDLE: start wins.
    start_i = 1'b1; cancel_i = 1'b1; level_i = 2'd0;
    tick();
    start_i = 1'b0; cancel_i = 1'b0;
    check("start_plus_cancel state", int'(state_o), int'(WARMUP));
    check("start_plus_cancel heater", int'(heater_o), 1);

    // Reset in the middle of TOAST clears outputs without a clock edge.
    for (int i = 0; i < 14; i++) tick();
    check("pre_reset in TOAST", int'(state_o), int'(TOAST));
    rst = 1'b1;
    #2;
    check("async_rst state", int'(state_o), int'(IDLE));
    check("async_rst heater", int'(heater_o), 0);
    check("async_rst busy", int'(busy_o), 0);
    tick();
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_o !== 1'b0 || state_o !== 2'b00) errs++;
      tick();
    end
    check("no_done_after_rst", errs, 0);

    // A start presented in the done cycle is accepted.
    start_i = 1'b1; level_i = 2'd0;
    tick();
    start_i = 1'b0;
    wait_done("back_to_back timeout");
    check("done_cycle idle", int'(state_o), int'(IDLE));
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("back_to_back restart", int'(state_o), int'(WARMUP));
    check("back_to_back done low", int'(done_o), 0);
    do_reset();

`ifdef TOASTER_SEQ_OVERTEMP_EN
    start_i = 1'b1; level_i = 2'd2;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    overtemp_i = 1'b1;
    tick();
    overtemp_i = 1'b0;
    check("overtemp state", int'(state_o), int'(COOL_DOWN));
    check("overtemp heater", int'(heater_o), 0);
    check("overtemp fault", int'(fault_o), 1);
    wait_done("overtemp timeout");
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("fault blocks start", int'(state_o), int'(IDLE));
    check("fault sticky", int'(fault_o), 1);
    do_reset();
    check("fault cleared by rst", int'(fault_o), 0);
`else
    start_i = 1'b1; level_i = 2'd2;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    overtemp_i = 1'b1;
    tick();
    overtemp_i = 1'b0;
    check("overtemp ignored state", int'(state_o), int'(TOAST));
    check("overtemp ignored heater", int'(heater_o), 1);
    check("overtemp ignored fault", int'(fault_o), 0);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
